prog_ctr: RTL and testbench

PROG_CTR -- requirements
Module: prog_ctr

---
 rtl/prog_ctr.sv | 202 ++++++++++++++++++++
 tb/tb_prog_ctr.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/prog_ctr.sv
// -----------------------------------------------------------------------------
// prog_ctr: program counter sequencer with IDLE/RUN/HALT control, absolute and
// relative branching, a saturating RUN-cycle counter and an optional 4-entry
// subroutine return stack.
//
// Build option: define PC_RET_STACK_EN to include the return stack. Without it,
// call_i behaves as an absolute branch, ret_i is ignored and stack_err_o is 0.
//
// Parameters:
//   D   program-counter / branch-target width
//   CW  cycle-counter width
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   reset_i      synchronous active-high reset
//   start_i      launch / relaunch execution from address 0
//   done_i       program-complete flag from the decoder
//   br_abs_i     absolute branch to target_i
//   br_rel_i     relative branch, target_i as a two's-complement offset
//   call_i       subroutine call to target_i
//   ret_i        subroutine return
//   br_idx_i     branch-target index from the instruction
//   target_i     lookup-table result for br_idx_i (combinational)
//   lut_addr_o   lookup-table address, br_idx_i[2:0] (combinational)
//   lut_third_o  lookup-table extension bit, br_idx_i[3] (combinational)
//   prog_ctr_o   current instruction address
//   running_o    high while in RUN
//   halted_o     high while in HALT
//   cycle_cnt_o  RUN cycles since launch, saturating
//   stack_err_o  sticky return-stack overflow/underflow flag
// -----------------------------------------------------------------------------
module prog_ctr #(
    parameter int unsigned D  = 12,
    parameter int unsigned CW = 16
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic          done_i,
    input  logic          br_abs_i,
    input  logic          br_rel_i,
    input  logic          call_i,
    input  logic          ret_i,
    input  logic [3:0]    br_idx_i,
    input  logic [D-1:0]  target_i,
    output logic [2:0]    lut_addr_o,
    output logic          lut_third_o,
    output logic [D-1:0]  prog_ctr_o,
    output logic          running_o,
    output logic          halted_o,
    output logic [CW-1:0] cycle_cnt_o,
    output logic          stack_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [D-1:0]    pc_q, pc_d;
    logic [D-1:0]    pc_inc;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            running_q, halted_q;

`ifdef PC_RET_STACK_EN
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SPW   = 3;

    logic [D-1:0]    stack_q [DEPTH];
    logic [SPW-1:0]  sp_q, sp_d;
    logic [1:0]      pop_idx;
    logic            push_c;
    logic            err_q, err_d;
`else
    logic            unused_ret;
    assign unused_ret = ret_i;
`endif

    // Table lookup is driven straight from the instruction field.
    assign lut_addr_o  = br_idx_i[2:0];
    assign lut_third_o = br_idx_i[3];

    // Next-state, next-PC and counter logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        pc_inc  = pc_q + D'(1);
`ifdef PC_RET_STACK_EN
        sp_d    = sp_q;
        err_d   = err_q;
        push_c  = 1'b0;
        pop_idx = 2'(sp_q - SPW'(1));
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // The cycle in which done_i is sampled still counts.
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (done_i) begin
                    state_d = HALT;
`ifdef PC_RET_STACK_EN
                end else if (ret_i) begin
                    // Underflow falls back to a plain increment.
                    if (sp_q != '0) begin
                        pc_d = stack_q[pop_idx];
                        sp_d = sp_q - SPW'(1);
                    end else begin
                        pc_d  = pc_inc;
                        err_d = 1'b1;
                    end
                end else if (call_i) begin
                    // Overflow drops the return address but still branches.
                    pc_d = target_i;
                    if (sp_q == SPW'(DEPTH)) begin
                        err_d = 1'b1;
                    end else begin
                        push_c = 1'b1;
                        sp_d   = sp_q + SPW'(1);
                    end
`else
                end else if (call_i) begin
                    pc_d = target_i;
`endif
                end else if (br_abs_i) begin
                    pc_d = target_i;
                end else if (br_rel_i) begin
                    // Modular add doubles as two's-complement offset.
                    pc_d = pc_q + target_i;
                end else begin
                    pc_d = pc_inc;
                end
            end
            HALT: begin
                if (start_i) begin
                    state_d = RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, PC, counter and status registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            running_q <= (state_d == RUN);
            halted_q  <= (state_d == HALT);
        end
    end

`ifdef PC_RET_STACK_EN
    // Stack pointer and sticky error flag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Return-address storage; emptiness is tracked by sp_q alone.
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            stack_q[sp_q[1:0]] <= pc_inc;
        end
    end

    assign stack_err_o = err_q;
`else
    assign stack_err_o = 1'b0;
`endif

    assign prog_ctr_o  = pc_q;
    assign cycle_cnt_o = cnt_q;
    assign running_o   = running_q;
    assign halted_o    = halted_q;

endmodule

// File: tb/tb_prog_ctr.sv
// -----------------------------------------------------------------------------
// tb_prog_ctr: directed scoreboard bench for prog_ctr (D=12, CW=16). The driver
// pushes the expected post-edge state for each cycle it drives; a separate
// monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_prog_ctr;

    localparam logic [6:0] NO = 7'h00;
    localparam logic [6:0] RS = 7'h40;
    localparam logic [6:0] ST = 7'h20;
    localparam logic [6:0] DN = 7'h10;
    localparam logic [6:0] BA = 7'h08;
    localparam logic [6:0] BR = 7'h04;
    localparam logic [6:0] CL = 7'h02;
    localparam logic [6:0] RT = 7'h01;

    typedef struct {
        logic [11:0] pc;
        logic        run;
        logic        halt;
        logic [15:0] cnt;
        logic        err;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        done = 1'b0;
    logic        br_abs = 1'b0;
    logic        br_rel = 1'b0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [3:0]  br_idx = 4'd0;
    logic [11:0] target = 12'd0;
    logic [2:0]  lut_addr;
    logic        lut_third;
    logic [11:0] prog_ctr;
    logic        running;
    logic        halted;
    logic [15:0] cycle_cnt;
    logic        stack_err;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    prog_ctr #(.D(12), .CW(16)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .done_i      (done),
        .br_abs_i    (br_abs),
        .br_rel_i    (br_rel),
        .call_i      (call),
        .ret_i       (ret),
        .br_idx_i    (br_idx),
        .target_i    (target),
        .lut_addr_o  (lut_addr),
        .lut_third_o (lut_third),
        .prog_ctr_o  (prog_ctr),
        .running_o   (running),
        .halted_o    (halted),
        .cycle_cnt_o (cycle_cnt),
        .stack_err_o (stack_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic drive(input logic [6:0] ctl, input logic [11:0] tgt);
        @(negedge clk);
        {reset, start, done, br_abs, br_rel, call, ret} = ctl;
        target = tgt;
        @(posedge clk);
    endtask

    task automatic step(input logic [6:0] ctl, input logic [11:0] tgt,
                        input logic [11:0] epc, input logic erun, input logic ehalt,
                        input logic [15:0] ecnt, input logic eerr, input string nm);
        exp_t e;
        drive(ctl, tgt);
        e.pc = epc; e.run = erun; e.halt = ehalt; e.cnt = ecnt; e.err = eerr; e.nm = nm;
        sb_q.push_back(e);
    endtask

    // Monitor: compares one queued expectation per falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk({e.nm, ".pc"},   32'(prog_ctr),  32'(e.pc));
                chk({e.nm, ".run"},  32'(running),   32'(e.run));
                chk({e.nm, ".halt"}, 32'(halted),    32'(e.halt));
                chk({e.nm, ".cnt"},  32'(cycle_cnt), 32'(e.cnt));
                chk({e.nm, ".err"},  32'(stack_err), 32'(e.err));
            end
        end
    end

    // Driver
    initial begin
        logic [3:0] idx_v [4];
        int         waited;
        idx_v[0] = 4'b0000; idx_v[1] = 4'b1011; idx_v[2] = 4'b0110; idx_v[3] = 4'b1111;

        // Lookup outputs follow br_idx with no clock.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            br_idx = idx_v[i];
            #1;
            chk("lut_addr",  32'(lut_addr),  32'(idx_v[i] & 4'h7));
            chk("lut_third", 32'(lut_third), 32'(idx_v[i] >> 3));
        end
        br_idx = 4'd0;

        step(RS,      12'd0,   12'd0, 0, 0, 16'd0, 0, "reset0");
        step(RS | ST, 12'd0,   12'd0, 0, 0, 16'd0, 0, "reset_start");
        step(NO,      12'd0,   12'd0, 0, 0, 16'd0, 0, "idle");
        step(DN | BA, 12'd300, 12'd0, 0, 0, 16'd0, 0, "idle_ignore");
        step(ST,      12'd0,   12'd0, 1, 0, 16'd0, 0, "launch");
        for (int i = 1; i <= 10; i++)
            step(NO, 12'd0, 12'(i), 1, 0, 16'(i), 0, "inc");
        step(BA,      12'd285,  12'd285,  1, 0, 16'd11, 0, "br_abs");
        step(BR,      12'hFFB,  12'd280,  1, 0, 16'd12, 0, "br_rel_neg");
        step(BA,      12'd4090, 12'd4090, 1, 0, 16'd13, 0, "br_abs2");
        step(BR,      12'd20,   12'd14,   1, 0, 16'd14, 0, "br_rel_wrap");
        step(BA,      12'd4095, 12'd4095, 1, 0, 16'd15, 0, "br_abs_top");
        step(NO,      12'd0,    12'd0,    1, 0, 16'd16, 0, "inc_wrap");
        step(BA,      12'd5,    12'd5,    1, 0, 16'd17, 0, "br_abs5");
        step(BA,      12'd0,    12'd0,    1, 0, 16'd18, 0, "br_abs_zero");
        step(ST,      12'd0,    12'd1,    1, 0, 16'd19, 0, "start_in_run");
        step(BA | BR, 12'd100,  12'd100,  1, 0, 16'd20, 0, "abs_over_rel");
        step(BA,      12'd6,    12'd6,    1, 0, 16'd21, 0, "br_abs6");
        step(NO,      12'd0,    12'd7,    1, 0, 16'd22, 0, "inc7");
        step(DN | BA, 12'd100,  12'd7,    0, 1, 16'd23, 0, "done_abs");
        step(BA,      12'd200,  12'd7,    0, 1, 16'd23, 0, "halt_hold");
        step(ST,      12'd0,    12'd0,    1, 0, 16'd0,  0, "relaunch");
        step(BA,      12'd49,   12'd49,   1, 0, 16'd1,  0, "br_abs49");
        step(NO,      12'd0,    12'd50,   1, 0, 16'd2,  0, "inc50");
        step(RS | BA, 12'd99,   12'd0,    0, 0, 16'd0,  0, "reset_mid_run");
        step(ST,      12'd0,    12'd0,    1, 0, 16'd0,  0, "launch2");
        step(BA,      12'd20,   12'd20,   1, 0, 16'd1,  0, "br_abs20");
`ifdef PC_RET_STACK_EN
        step(CL,      12'd142,  12'd142,  1, 0, 16'd2,  0, "call");
        step(RT,      12'd0,    12'd21,   1, 0, 16'd3,  0, "ret");
        step(CL,      12'd30,   12'd30,   1, 0, 16'd4,  0, "call1");
        step(CL,      12'd40,   12'd40,   1, 0, 16'd5,  0, "call2");
        step(CL,      12'd50,   12'd50,   1, 0, 16'd6,  0, "call3");
        step(CL,      12'd60,   12'd60,   1, 0, 16'd7,  0, "call4");
        step(CL,      12'd70,   12'd70,   1, 0, 16'd8,  1, "call_full");
        step(RT,      12'd0,    12'd51,   1, 0, 16'd9,  1, "ret4");
        step(RT,      12'd0,    12'd41,   1, 0, 16'd10, 1, "ret3");
        step(RT,      12'd0,    12'd31,   1, 0, 16'd11, 1, "ret2");
        step(RT,      12'd0,    12'd22,   1, 0, 16'd12, 1, "ret1");
        step(RT,      12'd0,    12'd23,   1, 0, 16'd13, 1, "ret_empty");
        step(DN | RT, 12'd0,    12'd23,   0, 1, 16'd14, 1, "done_ret");
        step(ST,      12'd0,    12'd0,    1, 0, 16'd0,  1, "err_sticky");
`else
        step(CL,      12'd142,  12'd142,  1, 0, 16'd2,  0, "call_as_abs");
        step(RT,      12'd0,    12'd143,  1, 0, 16'd3,  0, "ret_ignored");
        step(CL | BR, 12'd10,   12'd10,   1, 0, 16'd4,  0, "call_over_rel");
        step(DN | RT, 12'd0,    12'd10,   0, 1, 16'd5,  0, "done_ret");
        step(ST,      12'd0,    12'd0,    1, 0, 16'd0,  0, "relaunch_nostk");
`endif
        step(RS,      12'd0,    12'd0,    0, 0, 16'd0,  0, "reset_clr");
        step(ST,      12'd0,    12'd0,    1, 0, 16'd0,  0, "launch3");

        // Long free run to reach counter saturation and repeated PC wrap.
        for (int i = 1; i <= 65529; i++) drive(NO, 12'd0);
        for (int i = 65530; i <= 65537; i++)
            step(NO, 12'd0, 12'(i), 1, 0, (i > 65535) ? 16'hFFFF : 16'(i), 0, "sat");
        step(DN, 12'd0, 12'd1, 0, 1, 16'hFFFF, 0, "done_sat");
        drive(NO, 12'd0);

        waited = 0;
        while (sb_q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        if (sb_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
